// File: rtl/ch_interleave.sv
// Strobe-driven channel interleaver: snapshots NCH channel words per accepted strobe and
// serialises the active ones onto dout with a FIFO write enable. Optional header word: CH_HEADER_EN.
module ch_interleave #(
  parameter int WIDTH   = 16,
  parameter int CH_BITS = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            strobe,
  input  logic [CH_BITS-1:0]              channels,
  input  logic [(2**CH_BITS)*WIDTH-1:0]   din,
  input  logic                            ovf_clr,
  output logic [WIDTH-1:0]                dout,
  output logic                            en,
  output logic [CH_BITS-1:0]              sel,
  output logic                            busy,
  output logic                            overrun,
  output logic [15:0]                     frame_cnt
);

  localparam int NCH = 2**CH_BITS;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

`ifdef CH_HEADER_EN
  localparam int HW = WIDTH - 4;
`endif

  logic [0:0]                  state_q, state_d;
  logic [CH_BITS-1:0]          k_q, k_d;
  logic [CH_BITS-1:0]          last_q, last_d;
  logic [NCH-1:0][WIDTH-1:0]   snap_q, snap_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic                        hdr_q, hdr_d;
  logic [WIDTH-1:0]            dout_q, dout_d;
  logic                        en_q, en_d;
  logic [CH_BITS-1:0]          sel_q, sel_d;
  logic                        ovf_q, ovf_d;
  logic                        accept;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    last_d  = last_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    dout_d  = dout_q;
    sel_d   = sel_q;
    en_d    = 1'b0;

    // A new frame may start only while idle or while the final channel word is being loaded.
    accept = strobe && ((state_q == IDLE) || ((k_q == last_q) && !hdr_q));

    if (state_q == SEND) begin
      en_d = 1'b1;
      if (hdr_q) begin
`ifdef CH_HEADER_EN
        dout_d = {4'hA, HW'(cnt_q)};
`endif
        sel_d = '0;
        hdr_d = 1'b0;
      end else begin
        dout_d = snap_q[k_q];
        sel_d  = k_q;
        if (k_q == last_q) begin
          state_d = IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
    end

    if (accept) begin
      state_d = SEND;
      k_d     = '0;
      last_d  = channels;
      snap_d  = din;
      cnt_d   = cnt_q + 16'd1;
`ifdef CH_HEADER_EN
      hdr_d   = 1'b1;
`endif
    end

    // A dropped strobe takes priority over a clear in the same cycle.
    if (strobe && !accept) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      last_q  <= '0;
      snap_q  <= '0;
      cnt_q   <= '0;
      hdr_q   <= 1'b0;
      dout_q  <= '0;
      en_q    <= 1'b0;
      sel_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      last_q  <= last_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout      = dout_q;
  assign en        = en_q;
  assign sel       = sel_q;
  assign busy      = (state_q == SEND);
  assign overrun   = ovf_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_ch_interleave.sv
// Directed bench for ch_interleave; header-word scenario runs when CH_HEADER_EN is defined.
module tb_ch_interleave;

  localparam int WIDTH   = 16;
  localparam int CH_BITS = 3;
  localparam int NCH     = 2**CH_BITS;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   strobe;
  logic [CH_BITS-1:0]     channels;
  logic [NCH*WIDTH-1:0]   din;
  logic                   ovf_clr;
  logic [WIDTH-1:0]       dout;
  logic                   en;
  logic [CH_BITS-1:0]     sel;
  logic                   busy;
  logic                   overrun;
  logic [15:0]            frame_cnt;

  int total = 0;
  int bad   = 0;

  ch_interleave #(.WIDTH(WIDTH), .CH_BITS(CH_BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .strobe    (strobe),
    .channels  (channels),
    .din       (din),
    .ovf_clr   (ovf_clr),
    .dout      (dout),
    .en        (en),
    .sel       (sel),
    .busy      (busy),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input logic [15:0] base);
    for (int k = 0; k < NCH; k++) din[k*WIDTH +: WIDTH] = base + 16'(k);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    strobe   = 1'b0;
    channels = '0;
    din      = '0;
    ovf_clr  = 1'b0;
    do_reset();

    check("rst_dout", 32'(dout), 32'h0);
    check("rst_en", 32'(en), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovf", 32'(overrun), 32'h0);
    check("rst_cnt", 32'(frame_cnt), 32'h0);

`ifndef CH_HEADER_EN
    // 1: single 4-channel frame
    channels = 3'd3;
    set_din(16'h1000);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    check("t1_lat_en", 32'(en), 32'h0);
    check("t1_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_en", 32'(en), 32'h1);
      check("t1_dout", 32'(dout), 32'h1000 + 32'(k));
      check("t1_sel", 32'(sel), 32'(k));
    end
    step();
    check("t1_en_off", 32'(en), 32'h0);
    check("t1_busy_off", 32'(busy), 32'h0);
    check("t1_cnt", 32'(frame_cnt), 32'd1);
    check("t1_dout_hold", 32'(dout), 32'h1003);
    check("t1_sel_hold", 32'(sel), 32'd3);

    // 2: back-to-back 2-channel frames, strobe every 2 clocks
    do_reset();
    channels = 3'd1;
    for (int c = 0; c < 10; c++) begin
      strobe = (c % 2 == 0) && (c < 8);
      if (strobe) set_din(16'h2000 + 16'((c / 2) * 16));
      step();
      if (c >= 1 && c <= 8) begin
        check("t2_en", 32'(en), 32'h1);
        check("t2_dout", 32'(dout), 32'h2000 + 32'(((c - 1) / 2) * 16 + (c - 1) % 2));
        check("t2_sel", 32'(sel), 32'((c - 1) % 2));
      end
    end
    strobe = 1'b0;
    check("t2_en_off", 32'(en), 32'h0);
    check("t2_ovf", 32'(overrun), 32'h0);
    check("t2_cnt", 32'(frame_cnt), 32'd4);

    // 3: 8-channel frame, second strobe 3 clocks later is dropped
    do_reset();
    channels = 3'd7;
    set_din(16'h3000);
    for (int c = 0; c < 10; c++) begin
      strobe = (c == 0) || (c == 3);
      if (c == 3) set_din(16'h3100);
      step();
      if (c >= 1 && c <= 8) begin
        check("t3_en", 32'(en), 32'h1);
        check("t3_dout", 32'(dout), 32'h3000 + 32'(c - 1));
        check("t3_sel", 32'(sel), 32'(c - 1));
      end
      if (c == 3) check("t3_ovf_set", 32'(overrun), 32'h1);
    end
    strobe = 1'b0;
    check("t3_en_off", 32'(en), 32'h0);
    check("t3_cnt", 32'(frame_cnt), 32'd1);
    check("t3_ovf_sticky", 32'(overrun), 32'h1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(overrun), 32'h0);
    // clear and dropped strobe together: set wins
    strobe = 1'b1;
    step();
    ovf_clr = 1'b1;
    step();
    strobe  = 1'b0;
    ovf_clr = 1'b0;
    check("t3_set_wins", 32'(overrun), 32'h1);

    // 4: din change after acceptance does not affect frame
    do_reset();
    channels = 3'd2;
    set_din(16'h4000);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    din = '1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_dout", 32'(dout), 32'h4000 + 32'(k));
    end

    // 5: reset mid-frame
    do_reset();
    channels = 3'd5;
    set_din(16'h5000);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
    step();
    check("t5_word1", 32'(dout), 32'h5001);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("t5_en", 32'(en), 32'h0);
    check("t5_cnt", 32'(frame_cnt), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_dout", 32'(dout), 32'h0);
    step();
    check("t5_no_partial", 32'(en), 32'h0);
    channels = 3'd1;
    set_din(16'h5100);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("t5_new_dout", 32'(dout), 32'h5100 + 32'(k));
      check("t5_new_sel", 32'(sel), 32'(k));
    end
    check("t5_new_cnt", 32'(frame_cnt), 32'd1);

    // single-channel frames with strobe held: one word per clock, no gap
    do_reset();
    channels = 3'd0;
    for (int c = 0; c < 5; c++) begin
      strobe = (c < 3);
      din[WIDTH-1:0] = 16'h7000 + 16'(c);
      step();
      if (c >= 1 && c <= 3) begin
        check("t7_en", 32'(en), 32'h1);
        check("t7_dout", 32'(dout), 32'h7000 + 32'(c - 1));
      end
    end
    strobe = 1'b0;
    check("t7_en_off", 32'(en), 32'h0);
    check("t7_ovf", 32'(overrun), 32'h0);
    check("t7_cnt", 32'(frame_cnt), 32'd3);
`else
    // 6: header word ahead of each single-channel frame
    channels = 3'd0;
    set_din(16'h6000);
    for (int f = 1; f <= 2; f++) begin
      strobe = 1'b1;
      step();
      strobe = 1'b0;
      step();
      check("t6_hdr_en", 32'(en), 32'h1);
      check("t6_hdr", 32'(dout), 32'hA000 + 32'(f));
      check("t6_hdr_sel", 32'(sel), 32'h0);
      step();
      check("t6_ch0_en", 32'(en), 32'h1);
      check("t6_ch0", 32'(dout), 32'h6000);
      step();
      check("t6_en_off", 32'(en), 32'h0);
      step();
    end
    check("t6_cnt", 32'(frame_cnt), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ch_interleave.md
Name: ch_interleave

Overview:
- Parametrised successor to the strobe-driven channel sequencer and mux pair that feeds the FIFO.
- On each sample strobe it snapshots all channel words and serialises the active channels onto one data bus, one word per clock, with a write enable for the FIFO.
- Adds the following, which the previous sequencer did not have:
  - a coherent snapshot of all channels;
  - runtime channel count with clamping;
  - back-to-back frames;
  - a sticky overrun flag;
  - a frame counter.

Parameters:
- WIDTH, 16, bits per channel sample and per output word.
- CH_BITS, 3, select width; NCH = 2**CH_BITS channels supported.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk).
- strobe  in  1  sample-valid pulse; one frame per accepted strobe.
- channels  in  CH_BITS  active channel count minus one (0 = 1 channel); sampled only when a strobe is accepted.
- din  in  NCH*WIDTH  flat channel bus; channel k occupies din[k*WIDTH +: WIDTH].
- ovf_clr  in  1  clears overrun flag.
- dout  out  WIDTH  serialised data word, registered.
- en  out  1  dout valid / FIFO write enable, registered.
- sel  out  CH_BITS  index of the channel currently on dout, registered.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: a strobe was dropped.
- frame_cnt  out  16  accepted-frame counter, wraps at 65535 -> 0.

Behaviour:
- Reset (reset==0 at a clk edge) sets the following, regardless of state, including mid-frame:
  - dout=0, en=0, sel=0, busy=0, overrun=0, frame_cnt=0;
  - state=IDLE;
  - snapshot register cleared.
  - Any frame in progress is abandoned; no partial words are emitted after the reset edge.
- States:
  - IDLE: no frame active.
  - SEND: word index k counts 0..last, where last = latched channels value.
- Strobe acceptance: a strobe is accepted in IDLE, or in SEND on the cycle where k==last (last word of the frame being output).
- On acceptance at edge t:
  - snapshot <= din;
  - last <= channels;
  - frame_cnt increments;
  - state=SEND.
- Output timing for an accepted strobe:
  - First word: en=1, sel=0, dout=snapshot ch0, visible after edge t+1 (latency 1 clock from strobe).
  - Word k is visible after edge t+1+k.
  - en stays high for exactly last+1 consecutive cycles.
- After the last word:
  - If no new strobe was accepted, en=0 and state returns to IDLE.
  - If a new strobe was accepted on the last-word cycle, the next cycle outputs ch0 of the new snapshot. en stays continuously high, with no gap.
- busy is high whenever state==SEND.
- Strobe in SEND with k<last: the strobe is dropped and the current frame continues unaffected. overrun <= 1, and it stays set until ovf_clr.
- ovf_clr and a dropped strobe in the same cycle: overrun stays 1 (set wins).
- din changing during SEND has no effect on the frame.
- channels changing during SEND has no effect until the next accepted strobe.
- With all channels active (channels = NCH-1), a full frame is NCH words; strobe period >= NCH clocks gives zero overrun.
- When en=0: dout holds its last value and sel holds its last value.

Optional Feature:
- Macro: CH_HEADER_EN.
- Defined:
  - Every frame is preceded by one header word on dout with en=1 and sel=0.
  - Header contents: {4'hA, frame_cnt[WIDTH-5:0]}, using the post-increment count.
  - Channel words follow, so the frame is last+2 words long and first-channel latency becomes 2 clocks.
  - The back-to-back acceptance point is still the final channel word.
  - Requires WIDTH >= 8.
- Undefined: no header word; behaviour exactly as above.

Test Plan:
1. Reset then channels=3, din ch0..ch7=16'h1000..16'h1007, single strobe -> en high 4 cycles starting 1 clock after strobe; dout 1000,1001,1002,1003; sel 0..3; then en=0, busy=0, frame_cnt=1.
2. Back-to-back, channels=1, strobe every 2 clocks for 4 strobes -> en continuously high 8 cycles; overrun=0; frame_cnt=4.
3. channels=7, strobe at t and t+3 -> second strobe dropped, overrun=1, 8 words of the first frame only; then ovf_clr pulse -> overrun=0.
4. channels=2, strobe, then din changed to all 16'hFFFF one cycle later -> outputs still original snapshot values.
5. Reset asserted (0) on the cycle the second word is output in a channels=5 frame -> next edge en=0, frame_cnt=0, busy=0; the next strobe starts a fresh frame at ch0.
6. With CH_HEADER_EN defined, channels=0, two separated strobes -> per frame: header 16'hA001, then ch0; then header 16'hA002, then ch0; en high 2 cycles per frame.
